// File: rtl/vga_pkg.sv
// Shared VGA timing types: raster timing record, standard presets and the
// per-pixel raster bundle carried through the output pipeline.
package vga_pkg;

    localparam int COORD_W = 12;

    typedef struct packed {
        logic [COORD_W-1:0] h_active;
        logic [COORD_W-1:0] h_fp;
        logic [COORD_W-1:0] h_sync;
        logic [COORD_W-1:0] h_bp;
        logic [COORD_W-1:0] v_active;
        logic [COORD_W-1:0] v_fp;
        logic [COORD_W-1:0] v_sync;
        logic [COORD_W-1:0] v_bp;
        logic               h_pol;
        logic               v_pol;
    } vga_timing_t;

    // 25 MHz dot rate: CLK_DIV=4 from the 100 MHz system clock.
    localparam vga_timing_t VGA_640X480_60 = '{
        h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
        v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2,  v_bp: 12'd33,
        h_pol: 1'b0, v_pol: 1'b0
    };

    // 40 MHz dot rate: not an integer division of 100 MHz, needs its own clock.
    localparam vga_timing_t VGA_800X600_60 = '{
        h_active: 12'd800, h_fp: 12'd40, h_sync: 12'd128, h_bp: 12'd88,
        v_active: 12'd600, v_fp: 12'd1,  v_sync: 12'd4,   v_bp: 12'd23,
        h_pol: 1'b1, v_pol: 1'b1
    };

    typedef struct packed {
        logic               hsync;
        logic               vsync;
        logic               de;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               line_start;
        logic               frame_start;
    } vga_raster_t;

    function automatic vga_raster_t raster_idle(input logic h_pol, input logic v_pol);
        vga_raster_t r;
        r       = '0;
        r.hsync = ~h_pol;
        r.vsync = ~v_pol;
        return r;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enable gated shift register of raster bundles; DEPTH=0 is a wire.
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  vga_raster_t rst_val,
    input  vga_raster_t d,
    output vga_raster_t q
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, reset, ce, rst_val};
        assign q = d;
    end else begin : g_pipe
        vga_raster_t stage_q [DEPTH];
        vga_raster_t stage_d [DEPTH];

        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        always_comb begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i];
            end
            if (ce) begin
                stage_d[0] = d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i - 1];
                end
            end
        end

        // NOTE: the stages are reset like any other flop (they are not a RAM),
        // so downstream logic never sees stale sync levels after reset.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= rst_val;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign q = stage_q[DEPTH - 1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel clock-enable divider,
// h/v counters, combinational decode and a pixel-enable gated output pipeline.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV  = 4,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   PIPE     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic        pix_ce,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_width
        $fatal(1, "vga_timing_gen: every porch, sync and active width must be >= 1");
    end
    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
        $fatal(1, "vga_timing_gen: H_TOTAL and V_TOTAL must each be <= 4096");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $fatal(1, "vga_timing_gen: CLK_DIV must be in 1..16");
    end
    if (PIPE < 0 || PIPE > 8) begin : g_bad_pipe
        $fatal(1, "vga_timing_gen: PIPE must be in 0..8");
    end

    localparam logic [3:0]         DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEGIN = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEGIN = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam vga_raster_t RASTER_IDLE = raster_idle(H_POL, V_POL);

    logic [3:0]         div_q, div_d;
    logic               pix_ce_q, pix_ce_d;
    logic               advance;
    logic [COORD_W-1:0] hcnt_q, hcnt_d;
    logic [COORD_W-1:0] vcnt_q, vcnt_d;
    vga_raster_t        raster_s0;
    vga_raster_t        raster_q, raster_d;
    vga_raster_t        raster_out;

    // Divider: with CLK_DIV=1 div stays 0 and pix_ce is high every clk.
    always_comb begin
        div_d    = div_q;
        pix_ce_d = 1'b0;
        if (en) begin
            pix_ce_d = (div_q == DIV_LAST);
            div_d    = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        end
    end

    // A pixel slot is consumed only while running, so a slot pending when en
    // falls is dropped and the divider phase alone sets the resume point.
    assign advance = pix_ce_q & en;
    assign pix_ce  = advance;

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (advance) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + ONE;
            end else begin
                hcnt_d = hcnt_q + ONE;
            end
        end
    end

    always_comb begin
        raster_s0             = '0;
        raster_s0.de          = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        raster_s0.hsync       = ((hcnt_q >= HS_BEGIN) && (hcnt_q < HS_END)) ? H_POL : ~H_POL;
        raster_s0.vsync       = ((vcnt_q >= VS_BEGIN) && (vcnt_q < VS_END)) ? V_POL : ~V_POL;
        raster_s0.x           = raster_s0.de ? hcnt_q : '0;
        raster_s0.y           = raster_s0.de ? vcnt_q : '0;
        raster_s0.line_start  = (hcnt_q == '0);
        raster_s0.frame_start = (hcnt_q == '0) && (vcnt_q == '0);
    end

    always_comb begin
        raster_d = raster_q;
        if (advance) begin
            raster_d = raster_s0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= 4'd0;
            pix_ce_q <= 1'b0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            raster_q <= RASTER_IDLE;
        end else begin
            div_q    <= div_d;
            pix_ce_q <= pix_ce_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            raster_q <= raster_d;
        end
    end

    vga_delay_line #(
        .DEPTH (PIPE)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .ce      (advance),
        .rst_val (RASTER_IDLE),
        .d       (raster_q),
        .q       (raster_out)
    );

    assign hsync       = raster_out.hsync;
    assign vsync       = raster_out.vsync;
    assign de          = raster_out.de;
    assign x           = raster_out.x;
    assign y           = raster_out.y;
    assign line_start  = raster_out.line_start;
    assign frame_start = raster_out.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default timing at PIPE 2/0/8 and a
// small 14x8 raster exercising en freeze and mid-frame asynchronous reset.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam vga_timing_t DFLT  = VGA_640X480_60;
    localparam vga_timing_t SMALL = '{
        h_active: 12'd8, h_fp: 12'd2, h_sync: 12'd3, h_bp: 12'd1,
        v_active: 12'd4, v_fp: 12'd1, v_sync: 12'd2, v_bp: 12'd1,
        h_pol: 1'b1, v_pol: 1'b1
    };
    localparam int N_DEF = 1700;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b1, en_d = 1'b1;
    logic rst_s = 1'b1, en_s = 1'b1;

    logic        ce_w [4];
    logic        hs   [4];
    logic        vs   [4];
    logic        de_w [4];
    logic [11:0] x_w  [4];
    logic [11:0] y_w  [4];
    logic        ls   [4];
    logic        fs   [4];
    vga_raster_t obs  [4];
    vga_raster_t exp_q [4][$];

    int n_cmp = 0;
    int n_bad = 0;

    vga_timing_gen u_p2 (
        .clk(clk), .reset(rst_d), .en(en_d), .pix_ce(ce_w[0]), .hsync(hs[0]), .vsync(vs[0]),
        .de(de_w[0]), .x(x_w[0]), .y(y_w[0]), .line_start(ls[0]), .frame_start(fs[0]));

    vga_timing_gen #(.PIPE(0)) u_p0 (
        .clk(clk), .reset(rst_d), .en(en_d), .pix_ce(ce_w[1]), .hsync(hs[1]), .vsync(vs[1]),
        .de(de_w[1]), .x(x_w[1]), .y(y_w[1]), .line_start(ls[1]), .frame_start(fs[1]));

    vga_timing_gen #(.PIPE(8)) u_p8 (
        .clk(clk), .reset(rst_d), .en(en_d), .pix_ce(ce_w[2]), .hsync(hs[2]), .vsync(vs[2]),
        .de(de_w[2]), .x(x_w[2]), .y(y_w[2]), .line_start(ls[2]), .frame_start(fs[2]));

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE(0)
    ) u_small (
        .clk(clk), .reset(rst_s), .en(en_s), .pix_ce(ce_w[3]), .hsync(hs[3]), .vsync(vs[3]),
        .de(de_w[3]), .x(x_w[3]), .y(y_w[3]), .line_start(ls[3]), .frame_start(fs[3]));

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            obs[i]             = '0;
            obs[i].hsync       = hs[i];
            obs[i].vsync       = vs[i];
            obs[i].de          = de_w[i];
            obs[i].x           = x_w[i];
            obs[i].y           = y_w[i];
            obs[i].line_start  = ls[i];
            obs[i].frame_start = fs[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vga_raster_t idle_of(input vga_timing_t c);
        vga_raster_t r;
        r       = '0;
        r.hsync = ~c.h_pol;
        r.vsync = ~c.v_pol;
        return r;
    endfunction

    // Expected raster for one pixel slot, straight from the timing formulae.
    function automatic vga_raster_t model(input vga_timing_t c, input int slot);
        vga_raster_t r;
        int ht, vt, h, v, ha, va, hs0, hs1, vs0, vs1;
        ha  = int'(c.h_active);
        va  = int'(c.v_active);
        ht  = ha + int'(c.h_fp) + int'(c.h_sync) + int'(c.h_bp);
        vt  = va + int'(c.v_fp) + int'(c.v_sync) + int'(c.v_bp);
        hs0 = ha + int'(c.h_fp);
        hs1 = hs0 + int'(c.h_sync);
        vs0 = va + int'(c.v_fp);
        vs1 = vs0 + int'(c.v_sync);
        h   = slot % ht;
        v   = (slot / ht) % vt;
        r             = '0;
        r.de          = (h < ha) && (v < va);
        r.hsync       = (h >= hs0 && h < hs1) ? c.h_pol : ~c.h_pol;
        r.vsync       = (v >= vs0 && v < vs1) ? c.v_pol : ~c.v_pol;
        r.x           = r.de ? 12'(h) : 12'd0;
        r.y           = r.de ? 12'(v) : 12'd0;
        r.line_start  = (h == 0);
        r.frame_start = (h == 0) && (v == 0);
        return r;
    endfunction

    task automatic push_seq(input int k, input vga_timing_t c, input int n_idle,
                            input int first, input int n);
        for (int i = 0; i < n_idle; i++) exp_q[k].push_back(idle_of(c));
        for (int s = first; s < first + n; s++) exp_q[k].push_back(model(c, s));
    endtask

    function automatic logic rst_of(input int k);
        return (k == 3) ? rst_s : rst_d;
    endfunction

    // Inputs change only between a rising edge and the following falling edge,
    // so pix_ce seen on a falling edge tells whether the next rising edge
    // updates the outputs.
    task automatic monitor(input int k);
        logic pending = 1'b0;
        int   n_upd   = 0;
        vga_raster_t e;
        forever begin
            @(negedge clk);
            if (rst_of(k)) begin
                pending = 1'b0;
            end else begin
                if (pending && exp_q[k].size() > 0) begin
                    e = exp_q[k].pop_front();
                    check($sformatf("raster dut%0d update %0d", k, n_upd), 64'(obs[k]), 64'(e));
                    n_upd++;
                end
                pending = ce_w[k];
            end
        end
    endtask

    task automatic default_test();
        logic pend0 = 1'b0;
        logic de_prev = 1'b0, hs_prev = 1'b1;
        int fs_first = -1, de_rise1 = -1, de_rise2 = -1, hs_fall = -1, hs_rise = -1;
        vga_raster_t hist[$];
        repeat (3) @(negedge clk);
        #1 rst_d = 1'b0;
        for (int k = 1; k <= 7000; k++) begin
            @(negedge clk);
            if (k <= 12) check($sformatf("pix_ce clk %0d", k), 64'(ce_w[0]), 64'(k % 4 == 0));
            if (fs[0] && fs_first < 0) fs_first = k;
            if (de_w[0] && !de_prev) begin
                if (de_rise1 < 0) de_rise1 = k;
                else if (de_rise2 < 0) de_rise2 = k;
            end
            if (!hs[0] && hs_prev && hs_fall < 0) hs_fall = k;
            if (hs[0] && !hs_prev && hs_fall >= 0 && hs_rise < 0) hs_rise = k;
            de_prev = de_w[0];
            hs_prev = hs[0];
            if (pend0) begin
                hist.push_back(obs[1]);
                if (hist.size() > 8) begin
                    check($sformatf("pipe8 vs pipe0 clk %0d", k), 64'(obs[2]), 64'(hist[0]));
                    void'(hist.pop_front());
                end
            end
            pend0 = ce_w[1];
        end
        check("default first frame_start clk", 64'(fs_first), 64'(13));
        check("default first de rise clk",     64'(de_rise1), 64'(13));
        check("default line period clk",       64'(de_rise2), 64'(13 + 3200));
        check("default hsync fall clk",        64'(hs_fall),  64'(13 + 656 * 4));
        check("default hsync rise clk",        64'(hs_rise),  64'(13 + 656 * 4 + 384));
    endtask

    task automatic small_test();
        localparam vga_raster_t HOLD_EXP = '{hsync: 1'b0, vsync: 1'b0, de: 1'b1,
            x: 12'd5, y: 12'd1, line_start: 1'b0, frame_start: 1'b0};
        int fs_first = -1, fs_second = -1, vs_cnt = 0;
        logic found;
        repeat (3) @(negedge clk);
        #1 rst_s = 1'b0;
        for (int j = 1; j <= 120; j++) begin
            @(negedge clk);
            if (fs[3]) begin
                if (fs_first < 0) fs_first = j;
                else if (fs_second < 0) fs_second = j;
            end
            if (j >= 2 && j <= 113 && vs[3]) vs_cnt++;
        end
        check("small first frame_start clk", 64'(fs_first), 64'(2));
        check("small frame period clk",      64'(fs_second - fs_first), 64'(112));
        check("small vsync high clks",       64'(vs_cnt), 64'(28));

        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            found = de_w[3] && x_w[3] == 12'd4 && y_w[3] == 12'd1;
        end
        check("small reached x=4 y=1", 64'(found), 64'(1));
        @(posedge clk);
        #1 en_s = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check($sformatf("freeze raster clk %0d", n), 64'(obs[3]), 64'(HOLD_EXP));
            check($sformatf("freeze pix_ce clk %0d", n), 64'(ce_w[3]), 64'(0));
        end
        @(posedge clk);
        #1 en_s = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 5 && !found; n++) begin
            @(negedge clk);
            found = de_w[3] && x_w[3] == 12'd6 && y_w[3] == 12'd1;
        end
        check("resume reaches x=6", 64'(found), 64'(1));

        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            found = de_w[3] && x_w[3] == 12'd3 && y_w[3] == 12'd2;
        end
        check("small reached x=3 y=2", 64'(found), 64'(1));
        #1 rst_s = 1'b1;
        exp_q[3].delete();
        push_seq(3, SMALL, 0, 0, 120);
        #1;
        check("async reset raster", 64'(obs[3]), 64'(0));
        check("async reset pix_ce", 64'(ce_w[3]), 64'(0));
        @(negedge clk);
        #1 rst_s = 1'b0;
        fs_first = -1;
        for (int j = 1; j <= 140; j++) begin
            @(negedge clk);
            if (fs[3] && fs_first < 0) fs_first = j;
        end
        check("restart frame_start clk", 64'(fs_first), 64'(2));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            fork
                automatic int k = i;
                monitor(k);
            join_none
        end
        push_seq(0, DFLT, 2, 0, N_DEF);
        push_seq(1, DFLT, 0, 0, N_DEF);
        push_seq(2, DFLT, 8, 0, N_DEF - 8);
        push_seq(3, SMALL, 0, 0, 336);
        fork
            default_test();
            small_test();
        join
        repeat (20) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("dut%0d expected queue drained", k), 64'(exp_q[k].size()), 64'(0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
